fifo_sync_prog: RTL and testbench

Parametrised synchronous FIFO that succeeds the fixed-configuration push/pull FIFO.
- Generalises data width and depth.
- Adds a selectable read mode: standard registered read, or first-word-fall-through (FWFT).
- Adds occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags with clear.
- Sits between stream producers and consumers. Drives the same push/pull/din/dout/empty/full signal set as the existing FIFO interface, plus the new status outputs.

---
 rtl/fifo_config.sv | 20 ++
 rtl/fifo_sync_prog_if.sv | 31 +++
 rtl/fifo_ram.sv | 23 ++
 rtl/fifo_sync_prog.sv | 121 ++++++++++++
 tb/tb_fifo_sync_prog.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fifo_config.sv
// rtl/fifo_config.sv - shared FIFO configuration defaults and types
package fifo_config;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int FWFT       = 0;
    localparam int AF_THRESH  = DEPTH - 2;
    localparam int AE_THRESH  = 1;
    localparam int SETUP_TIME = 1;
    localparam int HOLD_TIME  = 1;

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/fifo_sync_prog_if.sv
// rtl/fifo_sync_prog_if.sv - push/pull FIFO interface with status signals
interface fifo_if #(
    parameter int DATA_WIDTH = fifo_config::DATA_WIDTH,
    parameter int DEPTH      = fifo_config::DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  push;
    logic [DATA_WIDTH-1:0] din;
    logic                  pull;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output push, din, pull, err_clr,
        input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, din, pull, err_clr,
        output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - dual-port array, synchronous write, asynchronous read
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - parametrised synchronous FIFO, std/FWFT read, status and error flags
module fifo_sync_prog
    import fifo_config::fifo_mode_e;
    import fifo_config::FIFO_STD;
    import fifo_config::FIFO_FWFT;
#(
    parameter int DATA_WIDTH = fifo_config::DATA_WIDTH,
    parameter int DEPTH      = fifo_config::DEPTH,
    parameter int FWFT       = fifo_config::FWFT,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = fifo_config::AE_THRESH
) (
    input  logic  clk,
    input  logic  res,
    fifo_if.slave f
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync_prog: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_prog: AF_THRESH exceeds DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("fifo_sync_prog: AE_THRESH must be below DEPTH");
    end

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  empty, full, wr_en, rd_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // All flags come from the registered count only.
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign rd_en = f.pull & ~empty;
    assign wr_en = f.push & (~full | rd_en);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Clear first so a same-cycle error event wins.
        if (f.err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (f.push & full & ~f.pull) overflow_d  = 1'b1;
        if (f.pull & empty)          underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en & ~res),
        .waddr(wr_ptr_q),
        .wdata(f.din),
        .raddr(rd_ptr_q),
        .rdata(ram_rdata)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign f.dout = ram_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_en) dout_d = ram_rdata;
        end

        always_ff @(posedge clk) begin
            if (res) dout_q <= '0;
            else     dout_q <= dout_d;
        end

        assign f.dout = dout_q;
    end

    assign f.empty        = empty;
    assign f.full         = full;
    assign f.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign f.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign f.count        = count_q;
    assign f.overflow     = overflow_q;
    assign f.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb/tb_fifo_sync_prog.sv - scoreboard bench driving standard and FWFT instances in lockstep
module tb_fifo_sync_prog;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          res = 1'b1;
    logic          push = 1'b0;
    logic          pull = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] din = '0;

    fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_s ();
    fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_f ();

    assign if_s.push    = push;
    assign if_s.din     = din;
    assign if_s.pull    = pull;
    assign if_s.err_clr = err_clr;
    assign if_f.push    = push;
    assign if_f.din     = din;
    assign if_f.pull    = pull;
    assign if_f.err_clr = err_clr;

    fifo_sync_prog #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_std (
        .clk(clk),
        .res(res),
        .f  (if_s)
    );

    fifo_sync_prog #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_fwft (
        .clk(clk),
        .res(res),
        .f  (if_f)
    );

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] mq [$];
    bit            m_ov = 1'b0;
    bit            m_un = 1'b0;
    logic [DW-1:0] m_dout = '0;
    logic [DW-1:0] dcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string lbl);
        int n;
        n = mq.size();
        chk({lbl, "/s_count"}, 32'(if_s.count), 32'(n));
        chk({lbl, "/s_empty"}, 32'(if_s.empty), 32'(n == 0));
        chk({lbl, "/s_full"}, 32'(if_s.full), 32'(n == DEPTH));
        chk({lbl, "/s_aempty"}, 32'(if_s.almost_empty), 32'(n <= AE));
        chk({lbl, "/s_afull"}, 32'(if_s.almost_full), 32'(n >= AF));
        chk({lbl, "/s_ovf"}, 32'(if_s.overflow), 32'(m_ov));
        chk({lbl, "/s_unf"}, 32'(if_s.underflow), 32'(m_un));
        chk({lbl, "/s_dout"}, 32'(if_s.dout), 32'(m_dout));
        chk({lbl, "/f_count"}, 32'(if_f.count), 32'(n));
        chk({lbl, "/f_empty"}, 32'(if_f.empty), 32'(n == 0));
        chk({lbl, "/f_ovf"}, 32'(if_f.overflow), 32'(m_ov));
        chk({lbl, "/f_unf"}, 32'(if_f.underflow), 32'(m_un));
        if (n > 0) chk({lbl, "/f_dout"}, 32'(if_f.dout), 32'(mq[0]));
    endtask

    // One clock: drive, update the scoreboard at the edge, then compare 1 time unit later.
    task automatic step(input string lbl, input bit r, input bit p, input logic [DW-1:0] d,
                        input bit pl, input bit ec);
        bit m_full, m_empty, rd, wr;
        res = r; push = p; din = d; pull = pl; err_clr = ec;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_dout = '0;
        end else begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            rd = pl && !m_empty;
            wr = p && (!m_full || rd);
            if (rd) m_dout = mq.pop_front();
            if (wr) mq.push_back(d);
            if (ec) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
            if (p && m_full && !pl) m_ov = 1'b1;
            if (pl && m_empty)      m_un = 1'b1;
        end
        #1;
        res = 1'b0; push = 1'b0; din = '0; pull = 1'b0; err_clr = 1'b0;
        check_all(lbl);
    endtask

    initial begin
        step("reset0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step("reset1", 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);

        for (int i = 1; i <= 8; i++) step("fill", 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) step("fill2", 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("ovf", 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        step("full_pp", 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("unf", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step("empty_pp", 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        step("rd33", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr_vs_unf", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step("clr2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        step("fwft42", 1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        step("fwft43", 1'b0, 1'b1, 8'h43, 1'b0, 1'b0);
        step("fwft_pull", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("fwft_pull2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        dcnt = 8'h60;
        for (int i = 0; i < 4; i++) begin
            step("wrap_pre", 1'b0, 1'b1, dcnt, 1'b0, 1'b0);
            dcnt++;
        end
        for (int i = 0; i < 20; i++) begin
            case (i % 3)
                0: begin
                    step("wrap", 1'b0, 1'b1, dcnt, 1'b0, 1'b0);
                    dcnt++;
                end
                1: step("wrap", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
                default: begin
                    step("wrap", 1'b0, 1'b1, dcnt, 1'b1, 1'b0);
                    dcnt++;
                end
            endcase
        end

        for (int i = 0; i < 6; i++) step("wrap_drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step("pre_rst_pull", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("pre_rst_push", 1'b0, 1'b1, 8'h85, 1'b0, 1'b0);
        step("rst_mid", 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        step("post_push", 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        step("post_pull", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
